// File: rtl/ntt_out_collector_if.sv
// Bundle of the NTT result-capture control, stream, read and status signals.
// The master modport drives the collector; the slave modport belongs to the collector itself.
interface ntt_out_collector_if #(
   parameter int DW        = 32,
   parameter int MAX_DEPTH = 10
);
   logic                 start;
   logic [3:0]           ring_depth;
   logic [DW-1:0]        q;
   logic                 in_valid;
   logic [DW-1:0]        in_data;
   logic [MAX_DEPTH-1:0] rd_addr;
   logic [DW-1:0]        rd_data;
   logic                 busy;
   logic                 done;
   logic                 err;
`ifdef NTT_COLLECT_CHECK_EN
   logic                 exp_we;
   logic [MAX_DEPTH-1:0] exp_addr;
   logic [DW-1:0]        exp_data;
   logic [MAX_DEPTH:0]   mism_cnt;

   modport master (
      output start, ring_depth, q, in_valid, in_data, rd_addr,
      output exp_we, exp_addr, exp_data,
      input  rd_data, busy, done, err, mism_cnt
   );
   modport slave (
      input  start, ring_depth, q, in_valid, in_data, rd_addr,
      input  exp_we, exp_addr, exp_data,
      output rd_data, busy, done, err, mism_cnt
   );
`else
   modport master (
      output start, ring_depth, q, in_valid, in_data, rd_addr,
      input  rd_data, busy, done, err
   );
   modport slave (
      input  start, ring_depth, q, in_valid, in_data, rd_addr,
      output rd_data, busy, done, err
   );
`endif
endinterface

// File: rtl/ntt_out_collector.sv
// De-interleaves the NTT lane stream into natural order, applies the final "-q" and buffers it.
// One stage-1 register, buffer write one edge after accept; NTT_COLLECT_CHECK_EN adds an expected-value compare.
module ntt_out_collector #(
   parameter int DW        = 32,
   parameter int MAX_DEPTH = 10,
   parameter int PE_DEPTH  = 0
) (
   input logic                clk,
   input logic                reset,
   ntt_out_collector_if.slave bus
);

   localparam int LB = PE_DEPTH + 1;
   localparam int AW = MAX_DEPTH;
   localparam int CW = MAX_DEPTH + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    depth_q, depth_d;
   logic [CW-1:0] n_q, n_d;
   logic [CW-1:0] m_q, m_d;
   logic [DW-1:0] q_q, q_d;
   logic          err_q, err_d;

   logic          s1_vld_q, s1_vld_d;
   logic          s1_last_q, s1_last_d;
   logic [AW-1:0] s1_addr_q, s1_addr_d;
   logic [DW-1:0] s1_red_q, s1_red_d;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_data_q;

   logic          cfg_ok;
   logic          accept;
   logic          surplus;
   logic          wr_en;
   logic [3:0]    lane_sh;
   logic [AW-1:0] addr;
   logic [DW-1:0] red;

   assign cfg_ok = (bus.ring_depth >= 4'(LB)) && (bus.ring_depth <= 4'(MAX_DEPTH));

   // Once m reaches N the capture is only draining stage 1; anything arriving then is surplus.
   assign accept  = (state_q == S_COLLECT) && bus.in_valid && !bus.start && (m_q != n_q);
   assign surplus = bus.in_valid && !bus.start && !accept;

   // Lane index selects a block of N/LANES, the word's position within its lane is m >> LB.
   assign lane_sh = depth_q - 4'(LB);
   assign addr    = AW'(m_q >> LB) + (AW'(m_q[LB-1:0]) << lane_sh);
   assign red     = (bus.in_data >= q_q) ? (bus.in_data - q_q) : bus.in_data;

   assign wr_en   = s1_vld_q && !reset;

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      n_d       = n_q;
      q_d       = q_q;
      m_d       = m_q;
      err_d     = err_q;
      s1_vld_d  = accept;
      s1_last_d = accept && (m_q == n_q - CW'(1));
      s1_addr_d = addr;
      s1_red_d  = red;
      if (bus.start) begin
         if (cfg_ok) begin
            depth_d = bus.ring_depth;
            n_d     = CW'(1) << bus.ring_depth;
            q_d     = bus.q;
            m_d     = '0;
            err_d   = 1'b0;
            state_d = S_COLLECT;
         end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
      end else begin
         if (accept) begin
            m_d = m_q + CW'(1);
         end
         if (surplus) begin
            err_d = 1'b1;
         end
         if ((state_q == S_COLLECT) && s1_vld_q && s1_last_q) begin
            state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         depth_q   <= 4'(LB);
         n_q       <= '0;
         q_q       <= '0;
         m_q       <= '0;
         err_q     <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_addr_q <= '0;
         s1_red_q  <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         depth_q   <= depth_d;
         n_q       <= n_d;
         q_q       <= q_d;
         m_q       <= m_d;
         err_q     <= err_d;
         s1_vld_q  <= s1_vld_d;
         s1_last_q <= s1_last_d;
         s1_addr_q <= s1_addr_d;
         s1_red_q  <= s1_red_d;
         rd_data_q <= mem[bus.rd_addr];
      end
   end

   // Buffer contents survive reset; only the write strobe is gated.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[s1_addr_q] <= s1_red_q;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.busy    = (state_q == S_COLLECT);
   assign bus.done    = (state_q == S_DONE);
   assign bus.err     = err_q;

`ifdef NTT_COLLECT_CHECK_EN
   logic [DW-1:0] exp_mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_rd_q;
   logic          mism_q;
   logic [CW-1:0] mism_cnt_q;

   // Expected word is fetched alongside stage 1 so it lines up with the buffer write.
   always_ff @(posedge clk) begin
      if (bus.exp_we) begin
         exp_mem[bus.exp_addr] <= bus.exp_data;
      end
      exp_rd_q <= exp_mem[s1_addr_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mism_q     <= 1'b0;
         mism_cnt_q <= '0;
      end else begin
         mism_q <= wr_en && !bus.start && (s1_red_q != exp_rd_q);
         if (bus.start) begin
            mism_cnt_q <= '0;
         end else if (mism_q && (mism_cnt_q != '1)) begin
            mism_cnt_q <= mism_cnt_q + CW'(1);
         end
      end
   end

   assign bus.mism_cnt = mism_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_out_collector.sv
// Directed bench: narrow (PE_DEPTH=0) and wide (PE_DEPTH=1) collectors side by side.
module tb_ntt_out_collector;

   localparam logic [31:0] Q = 32'd8380417;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic early;
   logic [31:0] rv;

   always #5 clk = ~clk;

   ntt_out_collector_if #(.DW(32), .MAX_DEPTH(10)) bus0 ();
   ntt_out_collector_if #(.DW(32), .MAX_DEPTH(10)) bus1 ();

   ntt_out_collector #(.DW(32), .MAX_DEPTH(10), .PE_DEPTH(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0));
   ntt_out_collector #(.DW(32), .MAX_DEPTH(10), .PE_DEPTH(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));

   typedef struct {
      int          phase;
      bit          sel;
      logic [9:0]  addr;
      logic [31:0] exp;
   } rd_vec_t;

   rd_vec_t vecs[$];

   function automatic void add(input int p, input bit s, input int a, input logic [31:0] e);
      rd_vec_t v;
      v.phase = p;
      v.sel   = s;
      v.addr  = 10'(a);
      v.exp   = e;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   task automatic rd(input bit sel, input logic [9:0] a, output logic [31:0] d);
      if (sel) bus1.rd_addr = a;
      else     bus0.rd_addr = a;
      tick();
      d = sel ? bus1.rd_data : bus0.rd_data;
   endtask

   task automatic apply_phase(input int p);
      logic [31:0] d;
      foreach (vecs[i]) begin
         if (vecs[i].phase == p) begin
            rd(vecs[i].sel, vecs[i].addr, d);
            chk($sformatf("p%0d_dut%0d_addr%0d", p, vecs[i].sel, vecs[i].addr), d, vecs[i].exp);
         end
      end
   endtask

   task automatic start0(input logic [3:0] depth);
      bus0.start      = 1'b1;
      bus0.ring_depth = depth;
      bus0.q          = Q;
      tick();
      bus0.start      = 1'b0;
   endtask

   initial begin
      // phase 1: natural order, value m+1
      add(1, 0, 0,   32'd1);
      add(1, 0, 128, 32'd2);
      add(1, 0, 1,   32'd3);
      add(1, 0, 255, 32'd256);
      add(1, 0, 127, 32'd255);
      // phase 2: surplus word must not disturb the buffer
      add(2, 0, 0,   32'd1);
      add(2, 0, 128, 32'd2);
      // phase 3: write pending at reset is dropped
      add(3, 0, 0,   32'd1);
      // phase 4: single conditional subtraction
      add(4, 0, 0,   32'd5);
      add(4, 0, 1,   32'd0);
      add(4, 0, 2,   Q - 32'd1);
      add(4, 0, 3,   Q + 32'd1);
      add(4, 0, 128, 32'd11);
      add(4, 0, 131, 32'd17);
      // phase 5: only post-restart data survives
      add(5, 0, 0,   32'd7000);
      add(5, 0, 128, 32'd7001);
      add(5, 0, 49,  32'd7098);
      add(5, 0, 177, 32'd7099);
      add(5, 0, 255, 32'd7255);
      // phase 6: four lanes, N=1024
      add(6, 1, 0,    32'd1);
      add(6, 1, 256,  32'd2);
      add(6, 1, 512,  32'd3);
      add(6, 1, 768,  32'd4);
      add(6, 1, 257,  32'd6);
      add(6, 1, 1023, 32'd1024);

      reset = 1'b1;
      bus0.start = 0; bus0.ring_depth = 0; bus0.q = 0; bus0.in_valid = 0; bus0.in_data = 0; bus0.rd_addr = 0;
      bus1.start = 0; bus1.ring_depth = 0; bus1.q = 0; bus1.in_valid = 0; bus1.in_data = 0; bus1.rd_addr = 0;
`ifdef NTT_COLLECT_CHECK_EN
      bus0.exp_we = 0; bus0.exp_addr = 0; bus0.exp_data = 0;
      bus1.exp_we = 0; bus1.exp_addr = 0; bus1.exp_data = 0;
`endif
      repeat (3) tick();
      chk("rst_busy", 32'(bus0.busy), 0);
      chk("rst_done", 32'(bus0.done), 0);
      chk("rst_err", 32'(bus0.err), 0);
      chk("rst_rd_data", bus0.rd_data, 0);
`ifdef NTT_COLLECT_CHECK_EN
      chk("rst_mism_cnt", 32'(bus0.mism_cnt), 0);
`endif
      reset = 1'b0;
      tick();

`ifdef NTT_COLLECT_CHECK_EN
      bus0.exp_we = 1'b1;
      for (int a = 0; a < 256; a++) begin
         bus0.exp_addr = 10'(a);
         bus0.exp_data = (a < 128) ? 32'(2 * a + 1) : 32'(2 * (a - 128) + 2);
         if (a == 5 || a == 130 || a == 255) bus0.exp_data = 32'hDEAD;
         tick();
      end
      bus0.exp_we = 1'b0;
`endif

      // natural order
      start0(4'd8);
      chk("nat_busy", 32'(bus0.busy), 1);
      bus0.in_valid = 1'b1;
      for (int m = 0; m < 256; m++) begin
         bus0.in_data = 32'(m + 1);
         tick();
      end
      bus0.in_valid = 1'b0;
      chk("nat_done_at_last_accept", 32'(bus0.done), 0);
      tick();
      chk("nat_done_after_write", 32'(bus0.done), 1);
      chk("nat_busy_after_write", 32'(bus0.busy), 0);
`ifdef NTT_COLLECT_CHECK_EN
      repeat (2) tick();
      chk("mism_cnt", 32'(bus0.mism_cnt), 3);
`endif
      apply_phase(1);

      // surplus word after done
      bus0.in_valid = 1'b1;
      bus0.in_data  = 32'd999;
      tick();
      bus0.in_valid = 1'b0;
      tick();
      chk("surplus_err", 32'(bus0.err), 1);
      chk("surplus_done_held", 32'(bus0.done), 1);
      apply_phase(2);
      start0(4'd8);
      chk("start_clears_err", 32'(bus0.err), 0);

      // reset one edge after an accept drops that word's write
      bus0.in_valid = 1'b1;
      bus0.in_data  = 32'd77;
      tick();
      bus0.in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_busy", 32'(bus0.busy), 0);
      tick();
      apply_phase(3);

      // illegal configurations
      start0(4'd11);
      chk("bad_cfg11_err", 32'(bus0.err), 1);
      chk("bad_cfg11_busy", 32'(bus0.busy), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_clears_err", 32'(bus0.err), 0);
      start0(4'd0);
      chk("bad_cfg0_err", 32'(bus0.err), 1);
      chk("bad_cfg0_busy", 32'(bus0.busy), 0);

      // reduction
      start0(4'd8);
      bus0.in_valid = 1'b1;
      for (int m = 0; m < 8; m++) begin
         case (m)
            0:       bus0.in_data = Q + 32'd5;
            2:       bus0.in_data = Q;
            4:       bus0.in_data = Q - 32'd1;
            6:       bus0.in_data = 32'd2 * Q + 32'd1;
            default: bus0.in_data = 32'(10 + m);
         endcase
         tick();
      end
      bus0.in_valid = 1'b0;
      tick();
      apply_phase(4);

      // restart after 100 words, with a word on the start cycle that must be ignored
      start0(4'd8);
      bus0.in_valid = 1'b1;
      for (int m = 0; m < 100; m++) begin
         bus0.in_data = 32'(5000 + m);
         tick();
      end
      bus0.start      = 1'b1;
      bus0.ring_depth = 4'd8;
      bus0.in_data    = 32'd1234;
      tick();
      bus0.start = 1'b0;
      chk("restart_err_clear", 32'(bus0.err), 0);
      early = 1'b0;
      for (int m = 0; m < 256; m++) begin
         bus0.in_data = 32'(7000 + m);
         tick();
         if (bus0.done) early = 1'b1;
      end
      bus0.in_valid = 1'b0;
      chk("restart_no_early_done", 32'(early), 0);
      tick();
      chk("restart_done", 32'(bus0.done), 1);
      apply_phase(5);

      // wide: two PEs, in_valid toggling
      bus1.start      = 1'b1;
      bus1.ring_depth = 4'd10;
      bus1.q          = Q;
      tick();
      bus1.start = 1'b0;
      chk("wide_busy", 32'(bus1.busy), 1);
      early = 1'b0;
      for (int m = 0; m < 1024; m++) begin
         bus1.in_valid = 1'b1;
         bus1.in_data  = 32'(m + 1);
         tick();
         if (bus1.done) early = 1'b1;
         bus1.in_valid = 1'b0;
         if (m < 1023) begin
            tick();
            if (bus1.done) early = 1'b1;
         end
      end
      chk("wide_no_early_done", 32'(early), 0);
      tick();
      chk("wide_done", 32'(bus1.done), 1);
      chk("wide_err", 32'(bus1.err), 0);
      apply_phase(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
